// File: rtl/z80_bus_sampler.sv
// z80_bus_sampler: synchronises and glitch-filters the raw Z80 bus pins.
// It holds a qualified address and strobe set for the address decoder for the
// whole bus cycle, and classifies each bus cycle into a one-entry event register.
module z80_bus_sampler #(
  parameter int FILT   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] z80_a,
  input  logic [DATA_W-1:0] z80_d_in,
  input  logic              z80_rd,
  input  logic              z80_wr,
  input  logic              z80_m1,
  input  logic              z80_iorq,
  input  logic              z80_mreq,
  output logic [ADDR_W-1:0] cyc_a,
  output logic              cyc_rd,
  output logic              cyc_wr,
  output logic              cyc_m1,
  output logic              cyc_iorq,
  output logic              cyc_mreq,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [2:0]        ev_type,
  output logic [ADDR_W-1:0] ev_addr,
  output logic [DATA_W-1:0] ev_data,
  output logic              ev_overrun,
  input  logic              ov_clr
);

  typedef enum logic [2:0] {S_IDLE, S_QUAL, S_RD_ACT, S_WR_ACT, S_BAD_ACT} state_t;

  localparam logic [2:0] FILT_C = 3'(FILT);

  // Strobe vector order is {rd, wr, m1, iorq, mreq}. All strobes are active-low.
  logic [4:0]        strb_s1_q, strb_s2_q;
  logic [ADDR_W-1:0] a_s1_q, a_s2_q;
  logic [DATA_W-1:0] d_s1_q, d_s2_q;
  logic [2:0]        ctl_q;

  // Two-flop synchronisers on every pin, plus one extra stage on m1/iorq/mreq.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the value its source held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the address/data synchronisers are reset as well. The event
      // fields that load from them then hold defined values from the start.
      strb_s1_q <= '1;
      strb_s2_q <= '1;
      a_s1_q    <= '0;
      a_s2_q    <= '0;
      d_s1_q    <= '0;
      d_s2_q    <= '0;
      ctl_q     <= '1;
    end else begin
      strb_s1_q <= {z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq};
      strb_s2_q <= strb_s1_q;
      a_s1_q    <= z80_a;
      a_s2_q    <= a_s1_q;
      d_s1_q    <= z80_d_in;
      d_s2_q    <= d_s1_q;
      ctl_q     <= strb_s2_q[2:0];
    end
  end

  logic rd_s, wr_s, m1_s, iorq_s, mreq_s;
  assign rd_s   = strb_s2_q[4];
  assign wr_s   = strb_s2_q[3];
  assign m1_s   = strb_s2_q[2];
  assign iorq_s = strb_s2_q[1];
  assign mreq_s = strb_s2_q[0];

  assign cyc_m1   = ctl_q[2];
  assign cyc_iorq = ctl_q[1];
  assign cyc_mreq = ctl_q[0];

  // Cycle class. The arguments are active-high "asserted" flags.
  function automatic logic [2:0] classify(input logic is_rd, input logic is_wr,
                                          input logic m1, input logic iorq,
                                          input logic mreq);
    if (is_rd && is_wr)            return 3'd7;
    else if (iorq && m1)           return 3'd5;
    else if (mreq && m1 && is_rd)  return 3'd4;
    else if (mreq)                 return is_rd ? 3'd0 : 3'd1;
    else if (iorq)                 return is_rd ? 3'd2 : 3'd3;
    else                           return 3'd7;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              qrd_q, qrd_d, qwr_q, qwr_d;
  logic [ADDR_W-1:0] cyc_a_q, cyc_a_d;
  logic              cyc_rd_q, cyc_rd_d, cyc_wr_q, cyc_wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              go_act, post;
  logic [2:0]        post_type;
  logic [ADDR_W-1:0] post_addr;
  logic [DATA_W-1:0] post_data;

  // Strobe qualification FSM: filter, hold the cycle, and request event posts.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    qrd_d     = qrd_q;
    qwr_d     = qwr_q;
    cyc_a_d   = cyc_a_q;
    cyc_rd_d  = cyc_rd_q;
    cyc_wr_d  = cyc_wr_q;
    wdata_d   = wdata_q;
    go_act    = 1'b0;
    post      = 1'b0;
    post_type = 3'd0;
    post_addr = a_s2_q;
    post_data = '0;
    case (state_q)
      S_IDLE: begin
        if (!rd_s || !wr_s) begin
          qrd_d  = !rd_s;
          qwr_d  = !wr_s;
          cnt_d  = 3'd1;
          go_act = (FILT_C == 3'd1);
          if (!go_act) state_d = S_QUAL;
        end
      end
      S_QUAL: begin
        // Any qualifying strobe sampled high means a glitch: drop back silently.
        if ((qrd_q && rd_s) || (qwr_q && wr_s)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          go_act = (cnt_d == FILT_C);
        end
      end
      S_RD_ACT: begin
        if (rd_s) begin
          cyc_rd_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_WR_ACT: begin
        if (wr_s) begin
          cyc_wr_d  = 1'b1;
          state_d   = S_IDLE;
          post      = 1'b1;
          post_type = classify(1'b0, 1'b1, !m1_s, !iorq_s, !mreq_s);
          post_addr = cyc_a_q;
          post_data = wdata_q;
        end else begin
          wdata_d = d_s2_q;
        end
      end
      S_BAD_ACT: begin
        if (rd_s && wr_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The qualification edge picks the ACT state from the strobes sampled now.
    if (go_act) begin
      if (!rd_s && !wr_s) begin
        state_d   = S_BAD_ACT;
        post      = 1'b1;
        post_type = 3'd7;
      end else if (!rd_s) begin
        state_d   = S_RD_ACT;
        cyc_rd_d  = 1'b0;
        cyc_a_d   = a_s2_q;
        post      = 1'b1;
        post_type = classify(1'b1, 1'b0, !m1_s, !iorq_s, !mreq_s);
      end else begin
        state_d  = S_WR_ACT;
        cyc_wr_d = 1'b0;
        cyc_a_d  = a_s2_q;
        wdata_d  = d_s2_q;
      end
    end
  end

  // FSM and held-cycle registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      qrd_q    <= 1'b0;
      qwr_q    <= 1'b0;
      cyc_a_q  <= '0;
      cyc_rd_q <= 1'b1;
      cyc_wr_q <= 1'b1;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qrd_q    <= qrd_d;
      qwr_q    <= qwr_d;
      cyc_a_q  <= cyc_a_d;
      cyc_rd_q <= cyc_rd_d;
      cyc_wr_q <= cyc_wr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cyc_a  = cyc_a_q;
  assign cyc_rd = cyc_rd_q;
  assign cyc_wr = cyc_wr_q;

  logic              ev_valid_q, ev_overrun_q;
  logic [2:0]        ev_type_q;
  logic [ADDR_W-1:0] ev_addr_q;
  logic [DATA_W-1:0] ev_data_q;
  logic              consume;

  assign consume = ev_valid_q && ev_ready;

  // One-entry event register with a valid/ready handshake and a sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid_q   <= 1'b0;
      ev_type_q    <= 3'd0;
      ev_addr_q    <= '0;
      ev_data_q    <= '0;
      ev_overrun_q <= 1'b0;
    end else begin
      if (post && (!ev_valid_q || consume)) begin
        ev_valid_q <= 1'b1;
        ev_type_q  <= post_type;
        ev_addr_q  <= post_addr;
        ev_data_q  <= post_data;
      end else if (consume) begin
        ev_valid_q <= 1'b0;
      end
      // A drop on the same edge as ov_clr keeps the flag set.
      if (post && ev_valid_q && !consume) ev_overrun_q <= 1'b1;
      else if (ov_clr)                    ev_overrun_q <= 1'b0;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_type    = ev_type_q;
  assign ev_addr    = ev_addr_q;
  assign ev_data    = ev_data_q;
  assign ev_overrun = ev_overrun_q;

endmodule

// File: tb/tb_z80_bus_sampler.sv
// Testbench for z80_bus_sampler: directed latency/handshake/reset checks plus
// randomized bus cycles scored against a queue-based event model.
module tb_z80_bus_sampler;
  localparam int FILT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] z80_a;
  logic [7:0]  z80_d_in;
  logic        z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq;
  logic [15:0] cyc_a;
  logic        cyc_rd, cyc_wr, cyc_m1, cyc_iorq, cyc_mreq;
  logic        ev_valid, ev_ready, ev_overrun, ov_clr;
  logic [2:0]  ev_type;
  logic [15:0] ev_addr;
  logic [7:0]  ev_data;

  z80_bus_sampler #(.FILT(FILT), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .z80_a(z80_a), .z80_d_in(z80_d_in),
    .z80_rd(z80_rd), .z80_wr(z80_wr), .z80_m1(z80_m1), .z80_iorq(z80_iorq),
    .z80_mreq(z80_mreq), .cyc_a(cyc_a), .cyc_rd(cyc_rd), .cyc_wr(cyc_wr),
    .cyc_m1(cyc_m1), .cyc_iorq(cyc_iorq), .cyc_mreq(cyc_mreq),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_addr(ev_addr), .ev_data(ev_data), .ev_overrun(ev_overrun), .ov_clr(ov_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 1'b0;
  bit  rnd_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    step();
  endtask

  // Reference classification, read straight off the cycle-class table.
  function automatic logic [2:0] model_type(input bit rd, input bit wr, input bit m1,
                                            input bit iorq, input bit mreq);
    if (rd && wr)          return 3'd7;
    if (iorq && m1)        return 3'd5;
    if (mreq && m1 && rd)  return 3'd4;
    if (mreq)              return rd ? 3'd0 : 3'd1;
    if (iorq)              return rd ? 3'd2 : 3'd3;
    return 3'd7;
  endfunction

  // One complete bus cycle. Control strobes lead the rd/wr strobe by a clock
  // and trail it by four, so they are stable whenever an event is posted.
  task automatic drive_cycle(input bit is_rd, input bit is_wr, input bit m1,
                             input bit iorq, input bit mreq, input logic [15:0] addr,
                             input logic [7:0] data, input int low_clks);
    z80_a = addr; z80_d_in = data;
    z80_m1 = !m1; z80_iorq = !iorq; z80_mreq = !mreq;
    step();
    z80_rd = !is_rd; z80_wr = !is_wr;
    repeat (low_clks) step();
    z80_rd = 1'b1; z80_wr = 1'b1;
    repeat (4) step();
    z80_m1 = 1'b1; z80_iorq = 1'b1; z80_mreq = 1'b1;
    repeat (2) step();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && ev_valid; i++) step();
    check("drain_timeout", ev_valid, 1'b0);
  endtask

  // Randomises ev_ready during the random phase only.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_en) ev_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor: a valid&ready pair seen here is consumed on the next edge.
  initial forever begin
    @(negedge clk);
    if (mon_en && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got type %0d addr 0x%0h data 0x%0h, expected no event",
                 ev_type, ev_addr, ev_data);
      end else begin
        mon_e = sb.pop_front();
        check("sb_type", ev_type, mon_e.typ);
        check("sb_addr", ev_addr, mon_e.addr);
        check("sb_data", ev_data, mon_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    z80_a = '0; z80_d_in = '0;
    z80_rd = 1'b1; z80_wr = 1'b1; z80_m1 = 1'b1; z80_iorq = 1'b1; z80_mreq = 1'b1;
    ev_ready = 1'b0; ov_clr = 1'b0; rst = 1'b1;
    repeat (3) step();
    check("rst_cyc_strobes", {cyc_rd, cyc_wr, cyc_m1, cyc_iorq, cyc_mreq}, 5'h1F);
    check("rst_cyc_a", cyc_a, 16'h0);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_fields", {ev_type, ev_addr, ev_data}, 27'h0);
    check("rst_ev_overrun", ev_overrun, 1'b0);
    rst = 1'b0;
    repeat (2) step();

    // Memory read: strobe latencies, held address, event at ACT entry.
    z80_a = 16'h1234; z80_mreq = 1'b0;
    repeat (2) step();
    check("mreq_lat_2", cyc_mreq, 1'b1);
    step();
    check("mreq_lat_3", cyc_mreq, 1'b0);
    z80_rd = 1'b0;
    repeat (3) step();
    check("rd_lat_3", cyc_rd, 1'b1);
    check("rd_no_ev_yet", ev_valid, 1'b0);
    step();
    check("rd_lat_4", cyc_rd, 1'b0);
    check("rd_cyc_a", cyc_a, 16'h1234);
    check("rd_ev", {ev_valid, ev_type, ev_addr, ev_data}, {1'b1, 3'd0, 16'h1234, 8'h00});
    z80_a = 16'hBEEF;
    repeat (16) step();
    check("rd_cyc_a_held", cyc_a, 16'h1234);
    z80_rd = 1'b1;
    repeat (2) step();
    check("rd_rel_2", cyc_rd, 1'b0);
    step();
    check("rd_rel_3", cyc_rd, 1'b1);
    z80_mreq = 1'b1;
    step();
    consume();
    check("rd_consumed", ev_valid, 1'b0);

    // IO write: posted on exit with data from the last synced-low sample.
    z80_a = 16'h00FE; z80_d_in = 8'hA5; z80_iorq = 1'b0;
    step();
    z80_wr = 1'b0;
    repeat (8) step();
    check("wr_cyc_wr", cyc_wr, 1'b0);
    check("wr_cyc_a", cyc_a, 16'h00FE);
    check("wr_no_ev_active", ev_valid, 1'b0);
    z80_wr = 1'b1; z80_d_in = 8'h3C;
    repeat (2) step();
    check("wr_rel_2", {cyc_wr, ev_valid}, 2'b00);
    step();
    check("wr_rel_3", cyc_wr, 1'b1);
    check("wr_ev", {ev_valid, ev_type, ev_addr, ev_data}, {1'b1, 3'd3, 16'h00FE, 8'hA5});
    z80_iorq = 1'b1;
    step();
    consume();
    drive_cycle(1, 0, 0, 0, 1, 16'h4000, 8'h77, 5);
    check("rd_after_wr_ev", {ev_valid, ev_type, ev_addr, ev_data}, {1'b1, 3'd0, 16'h4000, 8'h00});
    consume();

    // One-clock rd glitch: rejected, nothing changes.
    z80_a = 16'h7777; z80_mreq = 1'b0;
    step();
    z80_rd = 1'b0;
    step();
    z80_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("glitch_quiet", {cyc_rd, ev_valid}, 2'b10);
    end
    z80_mreq = 1'b1;
    step();

    // Overrun, set-wins-over-clear, consume-and-post on the same edge.
    drive_cycle(1, 0, 0, 0, 1, 16'h1111, 8'h00, 6);
    check("ov_first", {ev_valid, ev_addr, ev_overrun}, {1'b1, 16'h1111, 1'b0});
    drive_cycle(1, 0, 0, 0, 1, 16'h2222, 8'h00, 6);
    check("ov_dropped", {ev_valid, ev_addr, ev_overrun}, {1'b1, 16'h1111, 1'b1});
    repeat (3) step();
    check("ov_sticky", ev_overrun, 1'b1);
    ov_clr = 1'b1;
    step();
    ov_clr = 1'b0;
    check("ov_cleared", ev_overrun, 1'b0);
    z80_a = 16'h5555; z80_mreq = 1'b0;
    step();
    z80_rd = 1'b0;
    repeat (3) step();
    ov_clr = 1'b1;
    step();
    ov_clr = 1'b0;
    check("ov_set_wins", {ev_overrun, ev_addr}, {1'b1, 16'h1111});
    z80_rd = 1'b1;
    repeat (4) step();
    z80_mreq = 1'b1;
    ov_clr = 1'b1;
    step();
    ov_clr = 1'b0;
    z80_a = 16'h3333; z80_mreq = 1'b0;
    step();
    z80_rd = 1'b0;
    repeat (3) step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    check("consume_and_post", {ev_valid, ev_addr, ev_overrun}, {1'b1, 16'h3333, 1'b0});
    z80_rd = 1'b1;
    repeat (4) step();
    z80_mreq = 1'b1;
    step();
    consume();
    check("cp_drained", ev_valid, 1'b0);

    // Opcode fetch, then rd and wr low together.
    drive_cycle(1, 0, 1, 0, 1, 16'h0000, 8'h00, 4);
    check("m1_fetch_ev", {ev_valid, ev_type, ev_addr}, {1'b1, 3'd4, 16'h0000});
    consume();
    z80_a = 16'h0BAD; z80_mreq = 1'b0;
    step();
    z80_rd = 1'b0; z80_wr = 1'b0;
    repeat (4) step();
    check("bad_ev", {ev_valid, ev_type, ev_addr}, {1'b1, 3'd7, 16'h0BAD});
    repeat (4) step();
    check("bad_cyc_strobes", {cyc_rd, cyc_wr}, 2'b11);
    z80_rd = 1'b1; z80_wr = 1'b1;
    repeat (4) step();
    z80_mreq = 1'b1;
    step();
    consume();

    // Reset during WR_ACT with an event pending, then full re-qualification.
    drive_cycle(1, 0, 0, 0, 1, 16'h1357, 8'h00, 4);
    z80_a = 16'h2468; z80_d_in = 8'h5A; z80_mreq = 1'b0;
    step();
    z80_wr = 1'b0;
    repeat (5) step();
    check("pre_rst_wr", {cyc_wr, ev_valid}, 2'b01);
    rst = 1'b1;
    #1;
    check("rst_async", {cyc_wr, ev_valid, cyc_mreq, cyc_a}, {1'b1, 1'b0, 1'b1, 16'h0});
    step();
    rst = 1'b0;
    repeat (3) step();
    check("rst_requal_3", cyc_wr, 1'b1);
    step();
    check("rst_requal_4", {cyc_wr, cyc_a}, {1'b0, 16'h2468});
    z80_wr = 1'b1;
    repeat (3) step();
    check("rst_wr_ev", {ev_valid, ev_type, ev_addr, ev_data}, {1'b1, 3'd1, 16'h2468, 8'h5A});
    z80_mreq = 1'b1;
    step();
    consume();

    // Random bus cycles against the queue model.
    mon_en = 1'b1;
    rnd_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int          kind, low;
      bit          rd, wr, m1, iorq, mreq;
      logic [15:0] addr;
      logic [7:0]  data;
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      m1   = 1'($urandom_range(0, 1));
      iorq = 1'($urandom_range(0, 1));
      mreq = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      data = 8'($urandom);
      low  = $urandom_range(1, 6);
      if (low >= FILT)
        sb.push_back('{typ: model_type(rd, wr, m1, iorq, mreq), addr: addr,
                       data: (wr && !rd) ? data : 8'h00});
      drive_cycle(rd, wr, m1, iorq, mreq, addr, data, low);
      wait_drain();
    end
    rnd_en = 1'b0;
    ev_ready = 1'b0;
    repeat (2) step();
    mon_en = 1'b0;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
